// File: rtl/rr_mux_sel_pkg.sv
// Shared routing definitions for the round-robin mux-select arbiter:
// arbiter state encoding and a one-hot helper used to build grant vectors.
package rr_mux_sel_pkg;

    // Widest one-hot vector the helper can build; covers select widths up to 8.
    localparam int unsigned ONEHOT_W = 256;

    // Arbiter states: IDLE holds no grant, BUSY holds exactly one grant.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot code of idx within an n-wide vector; all zeros if idx is out of range.
    // Callers size-cast the result down to their own vector width.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx, input int unsigned n);
        onehot = (idx < n) ? (ONEHOT_W'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr,
// wrapping modulo N. The index arithmetic is S bits wide so it wraps on its own.
module rr_pick #(
    parameter int S = 3
) (
    input  logic [(1<<S)-1:0] req,
    input  logic [S-1:0]      ptr,
    output logic [S-1:0]      idx,
    output logic              any
);

    localparam int N = 1 << S;

    logic [S-1:0] offset;

    // Scan the request vector rotated by ptr from the top down, so that the
    // lowest rotated position with a request is the last one written.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[S'(i) + ptr]) begin
                offset = S'(i);
            end
        end
        any = |req;
        idx = offset + ptr;
    end

endmodule

// File: rtl/rr_mux_sel.sv
// Round-robin arbiter driving the select input of a recurse_mux. It holds each
// grant until the consumer pulses done, then rotates priority past the
// granted input, so every active requester is served within N grants.
module rr_mux_sel
    import rr_mux_sel_pkg::*;
#(
    parameter int S = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [(1<<S)-1:0]  req,
    input  logic               done,
    output logic [S-1:0]       ctrl,
    output logic [(1<<S)-1:0]  grant,
    output logic               valid
);

    localparam int unsigned N = 1 << S;

    state_t          state_q, state_d;
    logic [S-1:0]    ptr_q, ptr_d;
    logic [S-1:0]    ctrl_q, ctrl_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;

    logic            endOfTransfer;
    logic [S-1:0]    pickPtr;
    logic [S-1:0]    pickIdx;
    logic            pickAny;

    // A done while BUSY moves priority just past the current grant, and the
    // re-arbitration in that same cycle already uses the moved pointer.
    assign endOfTransfer = (state_q == BUSY) && done;
    assign pickPtr       = endOfTransfer ? (ctrl_q + S'(1)) : ptr_q;

    rr_pick #(.S(S)) u_pick (
        .req (req),
        .ptr (pickPtr),
        .idx (pickIdx),
        .any (pickAny)
    );

    // Next-state logic: hold everything unless idle or the transfer just ended.
    always_comb begin
        state_d = state_q;
        ptr_d   = pickPtr;
        ctrl_d  = ctrl_q;
        grant_d = grant_q;
        valid_d = valid_q;
        if ((state_q == IDLE) || endOfTransfer) begin
            if (pickAny) begin
                state_d = BUSY;
                ctrl_d  = pickIdx;
                grant_d = N'(onehot(32'(pickIdx), N));
                valid_d = 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    // State, pointer and output registers; reset overrides any pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ctrl_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ctrl_q  <= ctrl_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_sel.sv
// Bench for rr_mux_sel: an S=2 and an S=1 instance share clock, reset and done.
// A queue-free reference model tracks "who holds the grant" and "who is next in
// line" as plain integers, and every cycle both instances are compared with it.
module tb_rr_mux_sel;

    logic        clk;
    logic        rst;
    logic        done;
    logic [3:0]  req2;
    logic [1:0]  ctrl2;
    logic [3:0]  grant2;
    logic        valid2;
    logic [1:0]  req1;
    logic [0:0]  ctrl1;
    logic [1:0]  grant1;
    logic        valid1;

    int compareCount;
    int failCount;

    // Reference model state, index 0 is the S=2 instance, index 1 the S=1 one.
    int mBusy [2];
    int mPtr  [2];
    int mCtrl [2];

    rr_mux_sel #(.S(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .done  (done),
        .ctrl  (ctrl2),
        .grant (grant2),
        .valid (valid2)
    );

    rr_mux_sel #(.S(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .done  (done),
        .ctrl  (ctrl1),
        .grant (grant1),
        .valid (valid1)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of the behavioural arbiter for an n-input instance.
    task automatic modelStep(input int u, input int n, input int r, input bit d, input bit rs);
        int  j;
        bit  found;
        if (rs) begin
            mBusy[u] = 0;
            mPtr[u]  = 0;
            mCtrl[u] = 0;
        end else if (mBusy[u] == 0 || d) begin
            if (mBusy[u] != 0) mPtr[u] = (mCtrl[u] + 1) % n;
            found = 1'b0;
            for (int k = 0; k < n; k++) begin
                j = (mPtr[u] + k) % n;
                if (!found && ((r >> j) & 1) == 1) begin
                    mCtrl[u] = j;
                    found    = 1'b1;
                end
            end
            mBusy[u] = found ? 1 : 0;
        end
    endtask

    function automatic logic [31:0] expGrant(input int u);
        return (mBusy[u] != 0) ? (32'd1 << mCtrl[u]) : 32'd0;
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic applyStimulus(input logic [3:0] r2, input logic [1:0] r1, input logic d, input logic rs);
        req2 = r2;
        req1 = r1;
        done = d;
        rst  = rs;
        @(posedge clk);
        modelStep(0, 4, int'(r2), d, rs);
        modelStep(1, 2, int'(r1), d, rs);
        #1;
        checkOutput("valid2", 32'(valid2), 32'(mBusy[0]));
        checkOutput("grant2", 32'(grant2), expGrant(0));
        checkOutput("ctrl2",  32'(ctrl2),  32'(mCtrl[0]));
        checkOutput("valid1", 32'(valid1), 32'(mBusy[1]));
        checkOutput("grant1", 32'(grant1), expGrant(1));
        checkOutput("ctrl1",  32'(ctrl1),  32'(mCtrl[1]));
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        for (int u = 0; u < 2; u++) begin
            mBusy[u] = 0;
            mPtr[u]  = 0;
            mCtrl[u] = 0;
        end
        rst  = 1'b1;
        done = 1'b0;
        req2 = '0;
        req1 = '0;

        // Reset held two cycles with every input requesting.
        applyStimulus(4'b1111, 2'b00, 1'b0, 1'b1);
        applyStimulus(4'b1111, 2'b00, 1'b0, 1'b1);
        checkOutput("rst_valid", 32'(valid2), 32'd0);
        checkOutput("rst_grant", 32'(grant2), 32'd0);
        checkOutput("rst_ctrl",  32'(ctrl2),  32'd0);
        applyStimulus(4'b1111, 2'b00, 1'b0, 1'b0);
        checkOutput("first_ctrl", 32'(ctrl2), 32'd0);

        // Single request on input 2, held until done even after req drops.
        applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0);
        applyStimulus(4'b0100, 2'b00, 1'b0, 1'b0);
        checkOutput("single_grant", 32'(grant2), 32'h4);
        checkOutput("single_ctrl",  32'(ctrl2),  32'd2);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 2'b00, 1'b0, 1'b0);
        checkOutput("single_hold", 32'(valid2), 32'd1);
        applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0);
        checkOutput("single_release_valid", 32'(valid2), 32'd0);
        checkOutput("single_release_ctrl",  32'(ctrl2),  32'd2);

        // Rotation over all four inputs with done every third cycle.
        applyStimulus(4'b1111, 2'b00, 1'b0, 1'b1);
        applyStimulus(4'b1111, 2'b00, 1'b0, 1'b0);
        checkOutput("rot_ctrl0", 32'(ctrl2), 32'd0);
        for (int g = 1; g <= 4; g++) begin
            applyStimulus(4'b1111, 2'b00, 1'b0, 1'b0);
            applyStimulus(4'b1111, 2'b00, 1'b0, 1'b0);
            applyStimulus(4'b1111, 2'b00, 1'b1, 1'b0);
            checkOutput($sformatf("rot_ctrl%0d", g), 32'(ctrl2), 32'(g % 4));
            checkOutput($sformatf("rot_valid%0d", g), 32'(valid2), 32'd1);
        end

        // Skip and wrap: from a grant on input 3 the scan wraps to 0 first.
        applyStimulus(4'b1000, 2'b00, 1'b1, 1'b0);
        checkOutput("wrap_on3", 32'(ctrl2), 32'd3);
        applyStimulus(4'b0011, 2'b00, 1'b1, 1'b0);
        checkOutput("wrap_to0", 32'(ctrl2), 32'd0);
        applyStimulus(4'b0011, 2'b00, 1'b1, 1'b0);
        checkOutput("wrap_to1", 32'(ctrl2), 32'd1);

        // Reset together with done mid-transfer clears the pointer as well.
        applyStimulus(4'b0110, 2'b00, 1'b1, 1'b1);
        checkOutput("midrst_valid", 32'(valid2), 32'd0);
        applyStimulus(4'b0110, 2'b00, 1'b0, 1'b0);
        checkOutput("midrst_ctrl", 32'(ctrl2), 32'd1);

        // Spurious done while idle leaves everything alone.
        applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0);
        applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0);
        checkOutput("spur_valid", 32'(valid2), 32'd0);
        checkOutput("spur_ctrl",  32'(ctrl2),  32'd1);

        // Two-input instance alternates under continuous requests.
        applyStimulus(4'b0000, 2'b11, 1'b0, 1'b1);
        applyStimulus(4'b0000, 2'b11, 1'b0, 1'b0);
        checkOutput("s1_ctrl0", 32'(ctrl1), 32'd0);
        applyStimulus(4'b0000, 2'b11, 1'b0, 1'b0);
        applyStimulus(4'b0000, 2'b11, 1'b1, 1'b0);
        checkOutput("s1_ctrl1", 32'(ctrl1), 32'd1);
        applyStimulus(4'b0000, 2'b11, 1'b0, 1'b0);
        applyStimulus(4'b0000, 2'b11, 1'b1, 1'b0);
        checkOutput("s1_ctrl2", 32'(ctrl1), 32'd0);

        // Random traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/rr_mux_sel.md
# rr_mux_sel

Round-robin arbiter that produces the select code for a `recurse_mux` in the routing library. It sits directly upstream of the mux, and its `ctrl` output drives the mux's `ctrl` input. It takes one request line per mux input, grants one requester at a time, and holds the grant until the consumer signals end of transfer. It then rotates priority so that every active requester is served within N grants.

## Interface
Parameters:
- `S`, default 3: select width. The number of requesters is N = 2**S. Legal range is S >= 1.

Ports:
- `clk`, input, 1: the only clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: request vector; bit i requests mux input i.
- `done`, input, 1: one-cycle pulse from the consumer that ends the current grant.
- `ctrl`, output, S: binary index of the granted input. Connects to the mux `ctrl`.
- `grant`, output, N: one-hot grant vector; all zeros when idle.
- `valid`, output, 1: high while a grant is held, meaning `ctrl` selects a live source.

## Operation
- State machine with two states:
  - IDLE: no grant held.
  - BUSY: grant held.
- The priority pointer `ptr` is S bits wide and names the requester with highest priority.
- Arbitration:
  - The winner is the first set bit of `req` scanning from index `ptr` upward, wrapping from N-1 to 0.
  - The scan is modulo N with no out-of-range index; `ptr` wraps naturally in S bits.
  - An arbitration event occurs when (state == IDLE) or (state == BUSY and `done` == 1).
- On an arbitration event:
  - If `req` != 0: register `grant` = onehot(winner), `ctrl` = winner, `valid` = 1, state = BUSY.
  - If `req` == 0: `grant` = 0, `valid` = 0, state = IDLE. `ctrl` holds its last value so the mux output stays stable.
- On every `done` in BUSY, `ptr` becomes (granted index + 1) mod N. `ptr` is not updated on a grant; it is updated only on `done`.
- In BUSY without `done`, all outputs hold.
  - Deasserting `req` for the granted input does not release the grant.
  - Changes to other `req` bits are ignored.
- `done` in IDLE is ignored and does not move `ptr`.
- Back-to-back transfers: `done` with pending requests re-grants in the same cycle, so there is no idle bubble.
- A requester that keeps `req` asserted is re-granted only after every other active requester has been served once (fairness bound N grants).

## Timing
- All outputs are registered. There is no combinational path from `req` or `done` to any output.
- Reset values: `ctrl` = 0, `grant` = 0, `valid` = 0, `ptr` = 0, state = IDLE.
- Reset has priority over all other inputs. `rst` in the middle of BUSY drops the grant at that edge, and arbitration resumes the cycle after `rst` deasserts.
- Latency: `req` sampled at edge k in IDLE gives `grant`/`ctrl`/`valid` updated at edge k, visible in cycle k+1.
- `done` sampled at edge k gives the new grant, or `valid` = 0, visible in cycle k+1.
- Simultaneous `done` and `rst`: reset wins and `ptr` = 0.
- Invariants:
  - `grant` == onehot(`ctrl`) whenever `valid` = 1.
  - `grant` == 0 whenever `valid` = 0.
  - At most one grant bit is set in every cycle.

## Structure
- A shared routing package holds:
  - the state enum (IDLE, BUSY);
  - a function `onehot(idx, N)`.
- One combinational sub-module, `rr_pick`:
  - inputs `req[N-1:0]`, `ptr[S-1:0]`;
  - outputs `idx[S-1:0]`, `any`;
  - implementation: rotate `req` right by `ptr`, priority-encode the lowest set bit, add `ptr` back mod N.
- Top level: `rr_pick` plus the state register, `ptr` register and output registers.

## Test plan
Directed scenarios, using S = 2 unless stated otherwise:
1. Reset: hold `rst` = 1 for 2 cycles with `req` = 4'b1111. Required: `valid` = 0, `grant` = 0, `ctrl` = 0 throughout, and the first grant after release is `ctrl` = 0.
2. Single request: `req` = 4'b0100 in IDLE. Required:
   - next cycle `grant` = 4'b0100, `ctrl` = 2, `valid` = 1;
   - with `req` then dropped to 0, the grant holds until `done`;
   - the cycle after `done`: `valid` = 0, `ctrl` = 2.
3. Rotation: `req` = 4'b1111 held, `done` pulsed every 3rd cycle. Required: `ctrl` sequence 0, 1, 2, 3, 0 with no idle cycles between grants.
4. Skip and wrap:
   - grant held on input 3, then `req` = 4'b0011 with `done`. Required: next grant `ctrl` = 0, not 1.
   - then `done` again. Required: `ctrl` = 1.
5. Mid-transfer reset: grant held on input 1, assert `rst` together with `done`. Required: `valid` = 0 and `ptr` = 0; with `req` = 4'b0110 afterwards, the first grant is `ctrl` = 1.
6. Spurious `done` and S = 1:
   - `done` pulsed in IDLE with `req` = 0. Required: no output change.
   - with S = 1 and `req` = 2'b11 held with periodic `done`. Required: `ctrl` alternates 0, 1, 0.
